// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for the bit-serial adder. It provides the
//               FSM state encoding, the default operand width and the
//               bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // FSM state encoding. The values are fixed so that debug views stay
  // stable across revisions.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int c_DEFAULT_WIDTH = 8;

  // Bit-counter width. It must hold the values 0..w-1, and the legal w is at
  // least 2, so the result is always one bit or more.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Purely combinational 1-bit full adder.
//               The sum comes from an XOR pair. The carry comes from a
//               three-NAND majority network.
// Ports       : A, B, C  - addend bits and carry-in
//               Sum      - A ^ B ^ C
//               Carry    - majority(A, B, C)
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);

  logic w_axb;
  logic w_n_ab;
  logic w_n_bc;
  logic w_n_ac;

  assign w_axb  = A ^ B;
  assign Sum    = w_axb ^ C;

  // Each pairwise NAND is low when its pair is 1,1. The final NAND is
  // therefore high whenever at least two inputs are set.
  assign w_n_ab = ~(A & B);
  assign w_n_bc = ~(B & C);
  assign w_n_ac = ~(A & C);
  assign Carry  = ~(w_n_ab & w_n_bc & w_n_ac);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder that uses one full-adder cell and a
//               carry flip-flop. It loads operands on an accepted Start and
//               adds one bit pair per clock, LSB first. It then presents the
//               registered sum and carry-out together with a one-cycle Done.
// Ports       : Clk      - clock, rising edge
//               Rst      - synchronous active-high reset
//               Start    - request, sampled in IDLE or DONE only
//               OpA/OpB  - WIDTH-bit operands, captured on accepted Start
//               CarryIn  - initial carry, captured on accepted Start
//               Busy     - high while bit pairs are being added
//               Done     - one-cycle pulse when Sum/CarryOut update
//               Sum      - registered WIDTH-bit result
//               CarryOut - registered final carry
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
);

  localparam int              c_CW   = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_c;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_accept;

  fa_cell u_fa (
    .A     (r_a[0]),
    .B     (r_b[0]),
    .C     (r_c),
    .Sum   (w_s),
    .Carry (w_co)
  );

  assign w_last = (r_cnt == c_LAST);

  // Next-state logic and the decoded outputs.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        Busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        // A Start here begins the next add with no idle cycle in between.
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and datapath.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= OpA;
        r_b    <= OpB;
        r_c    <= CarryIn;
        r_cnt  <= '0;
        r_part <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a    <= r_a >> 1;
        r_b    <= r_b >> 1;
        // Sum bits enter at the MSB. After WIDTH shifts the LSB result bit
        // has reached bit 0.
        r_part <= {w_s, r_part[WIDTH-1:1]};
        r_c    <= w_co;
        r_cnt  <= r_cnt + c_ONE;
        if (w_last) begin
          // Publish the final bit straight from the cell. This avoids
          // waiting one more cycle for r_part to settle.
          r_sum <= {w_s, r_part[WIDTH-1:1]};
          r_co  <= w_co;
        end
      end
    end
  end

  assign Sum      = r_sum;
  assign CarryOut = r_co;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         CarryIn;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         CarryOut;

  int           tests  = 0;
  int           failed = 0;

  // Result currently held by the DUT, tracked by the bench.
  logic [W-1:0] e_sum = '0;
  logic         e_co  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .OpA      (OpA),
    .OpB      (OpB),
    .CarryIn  (CarryIn),
    .Busy     (Busy),
    .Done     (Done),
    .Sum      (Sum),
    .CarryOut (CarryOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance past the next rising edge. Inputs change here and outputs are
  // sampled here.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // One full add. inj_cyc > 0 pulses Start with junk operands during that
  // busy cycle. The pulse must be ignored.
  task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] xs, input logic xc,
                         input int inj_cyc);
    OpA = a; OpB = b; CarryIn = ci; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      check({tag, " busy"}, 32'(Busy), 32'(1));
      check({tag, " done_low"}, 32'(Done), 32'(0));
      check({tag, " sum_held"}, 32'({e_co, Sum}), 32'({e_co, e_sum}));
      check({tag, " co_held"}, 32'(CarryOut), 32'(e_co));
      if (c == inj_cyc) begin
        Start = 1'b1; OpA = 8'hAA; OpB = 8'hAA; CarryIn = 1'b1;
      end
      step();
      Start = 1'b0;
    end
    check({tag, " done"}, 32'(Done), 32'(1));
    check({tag, " busy_low"}, 32'(Busy), 32'(0));
    check({tag, " sum"}, 32'(Sum), 32'(xs));
    check({tag, " cout"}, 32'(CarryOut), 32'(xc));
    e_sum = xs; e_co = xc;
    step();
    check({tag, " idle_done"}, 32'(Done), 32'(0));
    check({tag, " idle_busy"}, 32'(Busy), 32'(0));
    check({tag, " idle_sum"}, 32'(Sum), 32'(xs));
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; OpA = '0; OpB = '0; CarryIn = 1'b0;
    step();
    step();
    check("rst busy", 32'(Busy), 32'(0));
    check("rst done", 32'(Done), 32'(0));
    check("rst sum", 32'(Sum), 32'(0));
    check("rst cout", 32'(CarryOut), 32'(0));
    Rst = 1'b0;
    step();
    check("idle busy", 32'(Busy), 32'(0));

    run_add("5A+33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0);
    run_add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run_add("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    run_add("ignore", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 4);

    // Abort an add with reset during busy cycle 5.
    OpA = 8'h0F; OpB = 8'h0F; CarryIn = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("abort busy", 32'(Busy), 32'(1));
      step();
    end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("abort busy_low", 32'(Busy), 32'(0));
    check("abort sum", 32'(Sum), 32'(0));
    check("abort cout", 32'(CarryOut), 32'(0));
    e_sum = '0; e_co = 1'b0;
    for (int c = 0; c < 2 * W; c++) begin
      check("abort no_done", 32'(Done), 32'(0));
      step();
    end
    run_add("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    // Start held high: results land at cycles 9 and 18 with no idle gap.
    OpA = 8'h80; OpB = 8'h80; CarryIn = 1'b0; Start = 1'b1;
    step();
    for (int c = 1; c <= 2 * (W + 1); c++) begin
      if (c == W + 1 || c == 2 * (W + 1)) begin
        check("b2b done", 32'(Done), 32'(1));
        check("b2b busy_low", 32'(Busy), 32'(0));
        check("b2b sum", 32'(Sum), 32'(8'h00));
        check("b2b cout", 32'(CarryOut), 32'(1));
      end else begin
        check("b2b busy", 32'(Busy), 32'(1));
        check("b2b done_low", 32'(Done), 32'(0));
      end
      if (c == 2 * (W + 1)) Start = 1'b0;
      step();
    end
    check("b2b idle", 32'(Busy), 32'(0));
    check("b2b idle_done", 32'(Done), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
